// File: rtl/scratch_pkg.sv
// Shared types and default widths for the scratch stack RAM.
// Imported by the storage array and the control top.
package scratch_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/scratch_mem_array.sv
// Single-port storage with synchronous write and a registered
// read-first output that holds whenever no read is requested.
module scratch_mem_array
  import scratch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_q <= '0;
    else if (i_re)
      r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/scratch_stack_ram.sv
// Scratch RAM with a downward-growing stack, direct access port
// and a self-clearing sequence after reset or on request.
module scratch_stack_ram
  import scratch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [ADDR_W-1:0] i_scr_addr,
  input  logic              i_scr_we,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data_out,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_busy,
  output logic              o_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_busy;
  logic              w_idle;
  logic              w_full;
  logic              w_empty;
  logic              w_op;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_do_rd;
  logic              w_err_ev;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_re;

  assign w_busy    = (r_state == CLEAR);
  assign w_idle    = (r_state == IDLE);
  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_op      = w_idle & ~i_clr;
  assign w_sp_dec  = r_sp - ADDR_W'(1);

  assign w_do_push = w_op & i_push & ~i_pop & ~w_full;
  assign w_do_pop  = w_op & i_pop & ~i_push & ~w_empty;
  assign w_do_rd   = w_op & ~i_push & ~i_pop;

  // Overflow, underflow and push/pop conflict all land here
  assign w_err_ev  = w_op & ((i_push & i_pop)
                   | (i_push & w_full)
                   | (i_pop & w_empty));

  always_comb begin
    w_addr  = i_scr_addr;
    w_wdata = i_data_in;
    w_we    = 1'b0;
    w_re    = 1'b0;
    unique case (1'b1)
      w_busy: begin
        w_addr  = r_clr_addr;
        w_wdata = '0;
        w_we    = 1'b1;
      end
      w_do_push: begin
        w_addr = w_sp_dec;
        w_we   = 1'b1;
      end
      w_do_pop: begin
        w_addr = r_sp;
        w_re   = 1'b1;
      end
      w_do_rd: begin
        w_re = 1'b1;
        w_we = i_scr_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_sp       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (r_clr_addr == ADDR_W'(DEPTH - 1))
            r_state <= IDLE;
        end
        IDLE: begin
          if (i_clr) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_sp       <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
          end else begin
            if (w_err_ev)
              r_err <= 1'b1;
            if (w_do_push) begin
              r_sp  <= w_sp_dec;
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_do_pop) begin
              r_sp  <= r_sp + ADDR_W'(1);
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  scratch_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (o_data_out)
  );

  assign o_sp    = r_sp;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_busy  = w_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_scratch_stack_ram.sv
// Randomized bench for scratch_stack_ram against an array/stack
// reference model plus directed corner scenarios.
module tb_scratch_stack_ram;

  localparam int DW    = 10;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] scr_addr = '0;
  logic          scr_we = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] sp;
  logic          full;
  logic          empty;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mem [DEPTH];
  int m_sp;
  int m_cnt;
  int m_busy;
  int m_err;
  int m_dout;

  always #5 clk = ~clk;

  scratch_stack_ram dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data_in  (data_in),
    .i_scr_addr (scr_addr),
    .i_scr_we   (scr_we),
    .i_push     (push),
    .i_pop      (pop),
    .i_clr      (clr),
    .o_data_out (data_out),
    .o_sp       (sp),
    .o_full     (full),
    .o_empty    (empty),
    .o_busy     (busy),
    .o_err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_sp = 0;
    m_cnt = 0;
    m_busy = DEPTH;
    m_err = 0;
    m_dout = 0;
  endfunction

  function automatic void mdl_edge();
    if (m_busy > 0) begin
      m_busy--;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_busy = DEPTH;
      m_sp = 0;
      m_cnt = 0;
      m_err = 0;
    end else if (push && pop) begin
      m_err = 1;
    end else if (push) begin
      if (m_cnt == DEPTH) m_err = 1;
      else begin
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        m_mem[m_sp] = int'(data_in);
        m_cnt++;
      end
    end else if (pop) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        m_dout = m_mem[m_sp];
        m_sp = (m_sp + 1) % DEPTH;
        m_cnt--;
      end
    end else begin
      m_dout = m_mem[scr_addr];
      if (scr_we) m_mem[scr_addr] = int'(data_in);
    end
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy > 0));
    chk({tag, ".full"}, 32'(full), 32'(m_cnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
    chk({tag, ".sp"}, 32'(sp), 32'(m_sp));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    mdl_edge();
    chk_all(tag);
  endtask

  task automatic quiet();
    scr_we = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int bc;
    bc = 0;
    while (busy === 1'b1 && bc < 1000) begin
      cyc(tag);
      bc++;
    end
    chk({tag, ".len"}, 32'(bc), 32'(DEPTH));
  endtask

  initial begin
    mdl_reset();
    #12;
    chk_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("init");

    foreach (m_mem[i]) begin
      if (i % 51 == 0) begin
        scr_addr = AW'(i);
        cyc("rd0");
        chk("rd0.zero", 32'(data_out), 32'h0);
      end
    end

    scr_addr = 8'h10;
    data_in = 10'h2AB;
    scr_we = 1'b1;
    cyc("wr");
    chk("wr.old", 32'(data_out), 32'h0);
    scr_we = 1'b0;
    cyc("wr_rd");
    chk("wr_rd.new", 32'(data_out), 32'h2AB);

    push = 1'b1;
    data_in = 10'h001;
    cyc("push1");
    data_in = 10'h002;
    cyc("push2");
    push = 1'b0;
    chk("push.sp", 32'(sp), 32'hFE);
    scr_addr = 8'hFF;
    cyc("rdff");
    chk("mem_ff", 32'(data_out), 32'h001);
    scr_addr = 8'hFE;
    cyc("rdfe");
    chk("mem_fe", 32'(data_out), 32'h002);
    pop = 1'b1;
    cyc("pop1");
    chk("pop1.d", 32'(data_out), 32'h002);
    cyc("pop2");
    chk("pop2.d", 32'(data_out), 32'h001);
    pop = 1'b0;
    chk("pop.sp", 32'(sp), 32'h00);
    chk("pop.empty", 32'(empty), 32'h1);

    pop = 1'b1;
    cyc("under");
    pop = 1'b0;
    chk("under.err", 32'(err), 32'h1);
    clr = 1'b1;
    cyc("clr");
    clr = 1'b0;
    wait_clear("clr");
    chk("clr.err", 32'(err), 32'h0);

    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = DW'($urandom_range(0, 1023));
      cyc("fill");
    end
    chk("fill.full", 32'(full), 32'h1);
    chk("fill.sp", 32'(sp), 32'h00);
    cyc("over");
    push = 1'b0;
    chk("over.sp", 32'(sp), 32'h00);
    chk("over.err", 32'(err), 32'h1);
    pop = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc("drain");
    pop = 1'b0;

    clr = 1'b1;
    cyc("clr2");
    clr = 1'b0;
    wait_clear("clr2");
    push = 1'b1;
    data_in = 10'h055;
    cyc("p55");
    pop = 1'b1;
    cyc("pp");
    chk("pp.sp", 32'(sp), 32'hFF);
    chk("pp.err", 32'(err), 32'h1);
    pop = 1'b0;
    scr_we = 1'b1;
    scr_addr = 8'h20;
    data_in = 10'h123;
    cyc("pwe");
    quiet();
    chk("pwe.sp", 32'(sp), 32'hFE);
    cyc("pwe_rd");
    chk("pwe.rd", 32'(data_out), 32'h000);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      quiet();
      data_in = DW'($urandom);
      scr_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom)
                 : AW'(m_sp + int'($urandom_range(0, 3)));
      if (r == 0) clr = 1'b1;
      else if (r < 8) begin push = 1'b1; pop = 1'b1; end
      else if (r < 80) push = 1'b1;
      else if (r < 140) pop = 1'b1;
      if ($urandom_range(0, 3) == 0) scr_we = 1'b1;
      cyc("rnd");
    end
    quiet();

    clr = 1'b1;
    cyc("clr3");
    clr = 1'b0;
    for (int i = 0; i < 100; i++) cyc("mid");
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk_all("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    rst_n = 1'b1;
    wait_clear("rerun");
    scr_addr = 8'h10;
    cyc("fin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
